imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_array.sv | 23 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: store geometry,
// masked-fetch filler word and loader FSM encoding.
package imem_loader_pkg;

  localparam int          IMEM_DEPTH    = 64;
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic logic count_legal(input logic [6:0] wc, input int depth);
    return (wc != 7'd0) && (int'(wc) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_array.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; visibility is controlled by the loader.
module imem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction store; gates CPU fetches
// until a complete program is resident.
//
// state | meaning
// IDLE  | no program resident, CPU stalled, waiting for load_start
// LOAD  | accepting bytes, assembling little-endian words
// RUN   | program resident, CPU released, fetches served from the store
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [6:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_fault,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [6:0]  word_ptr;
  logic [6:0]  latched_count;
  logic [6:0]  loaded_count;
  logic        load_err_q;

  logic        count_ok, start_ok, accept, word_we, last_word, fetch_hit;
  logic [31:0] rd_data;

  assign count_ok  = count_legal(word_count, DEPTH);
  assign start_ok  = load_start && count_ok && (state_q != LOAD);
  assign accept    = (state_q == LOAD) && byte_valid;
  // The pointer bound keeps a write from ever landing past the requested length.
  assign word_we   = accept && (byte_cnt == 2'd3) && (word_ptr < latched_count);
  assign last_word = word_we && (word_ptr == latched_count - 7'd1);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    cpu_stall  = 1'b1;
    load_done  = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: begin
        byte_ready = 1'b1;
        if (last_word) state_d = RUN;
      end
      RUN: begin
        cpu_stall = 1'b0;
        load_done = 1'b1;
        if (start_ok) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt      <= 2'd0;
      word_buf      <= 24'd0;
      word_ptr      <= 7'd0;
      latched_count <= 7'd0;
      loaded_count  <= 7'd0;
      load_err_q    <= 1'b0;
    end else begin
      load_err_q <= load_start && !count_ok && (state_q != LOAD);
      if (start_ok) begin
        byte_cnt      <= 2'd0;
        word_ptr      <= 7'd0;
        latched_count <= word_count;
        loaded_count  <= 7'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= byte_data;
          2'd1:    word_buf[15:8]  <= byte_data;
          2'd2:    word_buf[23:16] <= byte_data;
          default: ;
        endcase
        if (word_we)   word_ptr     <= word_ptr + 7'd1;
        if (last_word) loaded_count <= latched_count;
      end
    end
  end

  assign load_err = load_err_q;

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (word_we),
    .waddr (word_ptr[AW-1:0]),
    .wdata ({byte_data, word_buf}),
    .raddr (fetch_addr[AW+1:2]),
    .rdata (rd_data)
  );

  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:8] != 24'd0);
  assign fetch_hit   = !fetch_fault && (state_q == RUN)
                     && ({1'b0, fetch_addr[7:2]} < loaded_count);
  assign fetch_data  = fetch_hit ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [6:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;

  imem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .word_count  (word_count),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
    .cpu_stall   (cpu_stall),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        fault;
    logic        stall;
    logic        done;
    logic        err;
    logic        ready;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(e.name, "fetch_data",  fetch_data,          e.data);
      cmp(e.name, "fetch_fault", 32'(fetch_fault),    32'(e.fault));
      cmp(e.name, "cpu_stall",   32'(cpu_stall),      32'(e.stall));
      cmp(e.name, "load_done",   32'(load_done),      32'(e.done));
      cmp(e.name, "load_err",    32'(load_err),       32'(e.err));
      cmp(e.name, "byte_ready",  32'(byte_ready),     32'(e.ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the current cycle; the monitor checks it at the negedge.
  task automatic expect_out(input string nm, input logic [31:0] addr, input logic [31:0] data,
                            input logic fault, input logic stall, input logic done,
                            input logic err, input logic ready);
    exp_t e;
    fetch_addr = addr;
    e.name = nm; e.data = data; e.fault = fault; e.stall = stall;
    e.done = done; e.err = err; e.ready = ready;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [6:0] wc);
    load_start = 1'b1;
    word_count = wc;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    step();
    byte_valid = 1'b0;
  endtask

  logic [7:0] prog2 [8];

  initial begin
    prog2 = '{8'h83, 8'h20, 8'h00, 8'h00, 8'h03, 8'h21, 8'h40, 8'h00};
    rst = 1'b0; load_start = 1'b0; word_count = 7'd0;
    byte_valid = 1'b0; byte_data = 8'h00; fetch_addr = 32'd0;
    step(); step();
    expect_out("reset", 32'd0, NOP, 0, 1, 0, 0, 0);
    step();
    rst = 1'b1;
    step();

    // Illegal counts: error pulse, stay in IDLE
    pulse_start(7'd0);
    expect_out("err_wc0", 32'd0, NOP, 0, 1, 0, 1, 0);
    step();
    expect_out("err_wc0_clr", 32'd0, NOP, 0, 1, 0, 0, 0);
    pulse_start(7'd65);
    expect_out("err_wc65", 32'd0, NOP, 0, 1, 0, 1, 0);
    step();
    expect_out("err_wc65_clr", 32'd0, NOP, 0, 1, 0, 0, 0);

    // Two-word load
    pulse_start(7'd2);
    expect_out("load2_enter", 32'd0, NOP, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) send_byte(prog2[i]);
    expect_out("load2_pre_last", 32'd0, NOP, 0, 1, 0, 0, 1);
    send_byte(prog2[7]);
    expect_out("run_fetch0", 32'd0, 32'h0000_2083, 0, 0, 1, 0, 0);
    step();
    expect_out("run_fetch4", 32'd4, 32'h0040_2103, 0, 0, 1, 0, 0);
    step();
    expect_out("run_fetch8", 32'd8, NOP, 0, 0, 1, 0, 0);
    step();
    byte_valid = 1'b1; byte_data = 8'hEE;
    expect_out("run_misalign", 32'h0000_0002, NOP, 1, 0, 1, 0, 0);
    step();
    byte_valid = 1'b0;
    expect_out("run_oor", 32'h0000_0100, NOP, 1, 0, 1, 0, 0);
    step();
    expect_out("run_ignores_bytes", 32'd0, 32'h0000_2083, 0, 0, 1, 0, 0);
    step();

    // Reload one word from RUN with byte_valid toggling
    pulse_start(7'd1);
    expect_out("reload_stall", 32'd4, NOP, 0, 1, 0, 0, 1);
    send_byte(8'h11);
    byte_data = 8'hFF; step();
    send_byte(8'h22);
    byte_data = 8'hFF; step();
    send_byte(8'h33);
    byte_data = 8'hFF; step();
    byte_valid = 1'b1; byte_data = 8'h44;
    expect_out("reload_4th_byte", 32'd0, NOP, 0, 1, 0, 0, 1);
    step();
    byte_valid = 1'b0;
    expect_out("reload_fetch0", 32'd0, 32'h4433_2211, 0, 0, 1, 0, 0);
    step();
    expect_out("reload_fetch4_masked", 32'd4, NOP, 0, 0, 1, 0, 0);
    step();

    // Reset after 6 of 8 bytes
    pulse_start(7'd2);
    for (int i = 0; i < 6; i++) send_byte(prog2[i]);
    rst = 1'b0;
    step();
    rst = 1'b1;
    expect_out("midload_reset", 32'd0, NOP, 0, 1, 0, 0, 0);
    step();

    // Largest legal count is accepted
    pulse_start(7'd64);
    expect_out("wc64_accept", 32'd0, NOP, 0, 1, 0, 0, 1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Fresh one-word load; load_start mid-load must be ignored
    pulse_start(7'd1);
    send_byte(8'hAA);
    load_start = 1'b1; word_count = 7'd2;
    byte_valid = 1'b1; byte_data = 8'hBB;
    step();
    load_start = 1'b0;
    send_byte(8'hCC);
    send_byte(8'hDD);
    expect_out("fresh_fetch0", 32'd0, 32'hDDCC_BBAA, 0, 0, 1, 0, 0);
    step();
    expect_out("fresh_fetch4", 32'd4, NOP, 0, 0, 1, 0, 0);
    step();

    for (int i = 0; i < 4 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
